// File: rtl/move_scheduler_if.sv
// Move handshake between the scheduler (master) and the game datapath (slave).
interface move_scheduler_if;
    logic       move_req;
    logic       move_ack;
    logic [1:0] direction;

    modport master (
        output move_req,
        output direction,
        input  move_ack
    );

    modport slave (
        input  move_req,
        input  direction,
        output move_ack
    );
endinterface

// File: rtl/move_scheduler.sv
// Paces snake-style moves: waits PERIOD cycles, requests a move in the committed
// direction, and filters one-hot button presses into a pending direction.
module move_scheduler #(
    parameter int PERIOD = 50_000_000
) (
    input  logic             clock,
    input  logic             restart_n,
    input  logic             start,
    input  logic             pause,
    input  logic [3:0]       buttons,
    input  logic             game_over,
    move_scheduler_if.master mv,
    output logic             running,
    output logic [2:0]       db_state
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(PERIOD - 1);
    localparam logic [1:0]    DIR_RIGHT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_REQ       = 3'd2,
        S_PAUSED    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] tick_cnt_r;
    logic [CW-1:0] tick_cnt_s;
    logic          tick_last_s;
    logic [1:0]    dir_r;
    logic [1:0]    dir_s;
    logic [1:0]    pend_r;
    logic [1:0]    pend_s;
    logic [2:0]    btn_s;
    logic          move_req_r;
    logic          move_req_s;
    logic          running_r;
    logic          running_s;
    logic [2:0]    db_state_r;
    logic [2:0]    db_state_s;

    // Returns {valid, direction}; valid only when exactly one button is pressed.
    function automatic logic [2:0] decode_button(input logic [3:0] b);
        logic [2:0] res;
        case (b)
            4'b0001: res = {1'b1, 2'b00};
            4'b0010: res = {1'b1, 2'b01};
            4'b0100: res = {1'b1, 2'b10};
            4'b1000: res = {1'b1, 2'b11};
            default: res = {1'b0, 2'b00};
        endcase
        return res;
    endfunction

    assign tick_last_s = (tick_cnt_r == TICK_LAST);

    // State register.
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; game_over dominates, pause only matters while ticking.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_WAIT_TICK;
                else       state_s = S_IDLE;
            end
            S_WAIT_TICK: begin
                if (game_over)        state_s = S_DONE;
                else if (pause)       state_s = S_PAUSED;
                else if (tick_last_s) state_s = S_REQ;
                else                  state_s = S_WAIT_TICK;
            end
            S_REQ: begin
                if (game_over)        state_s = S_DONE;
                else if (mv.move_ack) state_s = S_WAIT_TICK;
                else                  state_s = S_REQ;
            end
            S_PAUSED: begin
                if (game_over)  state_s = S_DONE;
                else if (!pause) state_s = S_WAIT_TICK;
                else            state_s = S_PAUSED;
            end
            S_DONE: begin
                if (start) state_s = S_IDLE;
                else       state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Moore output decode, taken from the next state so the outputs can be registered.
    always_comb begin
        move_req_s = 1'b0;
        running_s  = 1'b0;
        db_state_s = state_s;
        case (state_s)
            S_WAIT_TICK: begin
                move_req_s = 1'b0;
                running_s  = 1'b1;
            end
            S_REQ: begin
                move_req_s = 1'b1;
                running_s  = 1'b1;
            end
            default: begin
                move_req_s = 1'b0;
                running_s  = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            move_req_r <= 1'b0;
            running_r  <= 1'b0;
            db_state_r <= 3'd0;
        end else begin
            move_req_r <= move_req_s;
            running_r  <= running_s;
            db_state_r <= db_state_s;
        end
    end

    // Tick counter next value: holds while paused or waiting for an ack.
    always_comb begin
        tick_cnt_s = tick_cnt_r;
        case (state_r)
            S_IDLE: begin
                tick_cnt_s = {CW{1'b0}};
            end
            S_WAIT_TICK: begin
                if (game_over)        tick_cnt_s = {CW{1'b0}};
                else if (pause)       tick_cnt_s = tick_cnt_r;
                else if (tick_last_s) tick_cnt_s = {CW{1'b0}};
                else                  tick_cnt_s = tick_cnt_r + CW'(1'b1);
            end
            S_REQ: begin
                if (mv.move_ack) tick_cnt_s = {CW{1'b0}};
                else             tick_cnt_s = tick_cnt_r;
            end
            default: tick_cnt_s = tick_cnt_r;
        endcase
    end

    // Tick counter register.
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            tick_cnt_r <= {CW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_s;
        end
    end

    // Direction filtering; reversal is judged against the direction being committed this cycle.
    always_comb begin
        btn_s  = decode_button(buttons);
        dir_s  = dir_r;
        pend_s = pend_r;
        if (state_r == S_WAIT_TICK && state_s == S_REQ) begin
            dir_s = pend_r;
        end else if (state_r == S_DONE && start) begin
            dir_s = DIR_RIGHT;
        end else begin
            dir_s = dir_r;
        end
        if (state_r == S_WAIT_TICK || state_r == S_REQ) begin
            if (btn_s[2] && (btn_s[1:0] != ~dir_s)) pend_s = btn_s[1:0];
            else                                   pend_s = pend_r;
        end else if (state_r == S_DONE && start) begin
            pend_s = DIR_RIGHT;
        end else begin
            pend_s = pend_r;
        end
    end

    // Committed and pending direction registers.
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            dir_r  <= DIR_RIGHT;
            pend_r <= DIR_RIGHT;
        end else begin
            dir_r  <= dir_s;
            pend_r <= pend_s;
        end
    end

    assign mv.move_req  = move_req_r;
    assign mv.direction = dir_r;
    assign running      = running_r;
    assign db_state     = db_state_r;

endmodule
